// File: rtl/sel_mux_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sel_mux_buf
// Purpose  : N-input WIDTH-bit selector with a one-entry registered output
//            buffer. Channel choice is either an explicit index (mode 0) or
//            round-robin among requesting channels (mode 1). All channels use
//            valid/ready handshakes; the consumer side may stall.
// Revision : 1.0 - initial release
// ============================================================================
module sel_mux_buf #(
   parameter int WIDTH = 5,
   parameter int N     = 2,
   parameter int SELW  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_chan,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam logic [SELW-1:0] C_LAST = SELW'(N - 1);

   // Output buffer and round-robin pointer
   logic [WIDTH-1:0] data_q, data_d;
   logic [SELW-1:0]  chan_q, chan_d;
   logic             valid_q, valid_d;
   logic [SELW-1:0]  ptr_q, ptr_d;

   // Grant path
   logic             can_load;
   logic             grant;
   logic             load;
   logic [SELW-1:0]  gidx;
   logic [WIDTH-1:0] gdata;

   // The buffer can take a word when empty or when its word leaves this cycle.
   assign can_load = !valid_q || out_ready;
   assign load     = can_load && grant;

   // Pick the granted channel: explicit index, or first valid starting at ptr.
   always_comb begin
      int c;
      grant = 1'b0;
      gidx  = '0;
      c     = 0;
      if (!mode) begin
         // Indices at or beyond N match no channel, so they never grant.
         for (int i = 0; i < N; i++) begin
            if ((sel == SELW'(i)) && in_valid[i]) begin
               grant = 1'b1;
               gidx  = SELW'(i);
            end
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            c = (int'(ptr_q) + k) % N;
            if (!grant && in_valid[c]) begin
               grant = 1'b1;
               gidx  = SELW'(c);
            end
         end
      end
   end

   // Route the granted channel's word toward the buffer register only.
   always_comb begin
      gdata = '0;
      for (int i = 0; i < N; i++) begin
         if (gidx == SELW'(i)) begin
            gdata = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // One-hot accept toward the producers; only the granted channel is consumed.
   for (genvar i = 0; i < N; i++) begin : g_ready
      assign in_ready[i] = load && (gidx == SELW'(i));
   end

   // Next-state for the buffer and the round-robin pointer.
   always_comb begin
      data_d  = data_q;
      chan_d  = chan_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (load) begin
         data_d  = gdata;
         chan_d  = gidx;
         valid_d = 1'b1;
         if (mode) begin
            ptr_d = (gidx == C_LAST) ? '0 : gidx + SELW'(1);
         end
      end else if (out_ready) begin
         // Word taken (or buffer already empty) with nothing to replace it.
         valid_d = 1'b0;
      end
   end

   // State registers; reset empties the buffer and restarts arbitration at 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         data_q  <= data_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_data  = data_q;
   assign out_chan  = chan_q;
   assign out_valid = valid_q;

endmodule
`default_nettype wire
